// File: rtl/in_service_control_pkg.sv
// Shared definitions for the 8259A in-service register stage.
//   IRQ_WIDTH / LEVEL_WIDTH : interrupt vector and level widths
//   ack_state_e             : INTA sequence state
//   onehot_to_level()       : encode one-hot IR to level (lowest bit wins, 0 -> spurious)
package in_service_control_pkg;

    localparam int IRQ_WIDTH   = 8;
    localparam int LEVEL_WIDTH = 3;
    localparam logic [LEVEL_WIDTH-1:0] SPURIOUS_LEVEL = 3'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_2ND = 2'd1,
        WAIT_3RD = 2'd2
    } ack_state_e;

    // An empty vector encodes as the spurious level (IR7). With several bits
    // set, the lowest one is reported.
    function automatic logic [LEVEL_WIDTH-1:0] onehot_to_level(input logic [IRQ_WIDTH-1:0] v);
        logic [LEVEL_WIDTH-1:0] lvl;
        lvl = SPURIOUS_LEVEL;
        for (int i = IRQ_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) lvl = LEVEL_WIDTH'(i);
        end
        return lvl;
    endfunction

endpackage

// File: rtl/in_service_control_if.sv
// Handshake/bus bundle for in_service_control.
//   master : controller side (drives INTA/OCW strobes, observes ISR state)
//   slave  : in_service_control side
interface in_service_control_if;
    import in_service_control_pkg::*;

    logic                   inta_pulse;
    logic                   mode_8086;
    logic                   auto_eoi_config;
    logic [IRQ_WIDTH-1:0]   acknowledge_interrupt;
    logic [IRQ_WIDTH-1:0]   interrupt_special_mask;
    logic                   eoi_strobe;
    logic                   eoi_specific;
    logic                   eoi_rotate;
    logic [LEVEL_WIDTH-1:0] eoi_level;
    logic                   set_priority_strobe;
    logic                   rotate_in_aeoi_set;
    logic                   rotate_in_aeoi_clear;

    logic [IRQ_WIDTH-1:0]   in_service_register;
    logic [LEVEL_WIDTH-1:0] priority_rotate;
    logic [IRQ_WIDTH-1:0]   highest_level_in_service;
    logic                   ack_busy;
    logic [LEVEL_WIDTH-1:0] ack_level;
    logic                   ack_done;

    modport master (
        output inta_pulse, mode_8086, auto_eoi_config, acknowledge_interrupt,
               interrupt_special_mask, eoi_strobe, eoi_specific, eoi_rotate,
               eoi_level, set_priority_strobe, rotate_in_aeoi_set, rotate_in_aeoi_clear,
        input  in_service_register, priority_rotate, highest_level_in_service,
               ack_busy, ack_level, ack_done
    );

    modport slave (
        input  inta_pulse, mode_8086, auto_eoi_config, acknowledge_interrupt,
               interrupt_special_mask, eoi_strobe, eoi_specific, eoi_rotate,
               eoi_level, set_priority_strobe, rotate_in_aeoi_set, rotate_in_aeoi_clear,
        output in_service_register, priority_rotate, highest_level_in_service,
               ack_busy, ack_level, ack_done
    );

endinterface

// File: rtl/in_service_control_hls.sv
// Highest-level-in-service resolver (combinational).
//   i_in_service_register : registered ISR
//   i_special_mask        : special-mask-mode bits, ignored when resolving
//   i_priority_rotate     : lowest-priority level; level rotate+1 is highest
//   o_highest_level       : one-hot highest-priority in-service level, 0 if none
module HighestLevelServiceModule
    import in_service_control_pkg::*;
(
    input  logic [IRQ_WIDTH-1:0]   i_in_service_register,
    input  logic [IRQ_WIDTH-1:0]   i_special_mask,
    input  logic [LEVEL_WIDTH-1:0] i_priority_rotate,
    output logic [IRQ_WIDTH-1:0]   o_highest_level
);

    // Walk levels from rotate+1 upward (mod 8); first unmasked ISR bit wins.
    function automatic logic [IRQ_WIDTH-1:0] resolve(
        input logic [IRQ_WIDTH-1:0]   isr,
        input logic [LEVEL_WIDTH-1:0] rot
    );
        logic [IRQ_WIDTH-1:0]   hit;
        logic [LEVEL_WIDTH-1:0] idx;
        logic                   found;
        hit   = '0;
        found = 1'b0;
        for (int k = 0; k < IRQ_WIDTH; k++) begin
            idx = rot + LEVEL_WIDTH'(1) + LEVEL_WIDTH'(k);
            if (!found && isr[idx]) begin
                hit[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return hit;
    endfunction

    logic [IRQ_WIDTH-1:0] w_masked;

    assign w_masked        = i_in_service_register & ~i_special_mask;
    assign o_highest_level = resolve(w_masked, i_priority_rotate);

endmodule

// File: rtl/in_service_control.sv
// 8259A in-service register stage.
//   i_clock, i_reset : clock and synchronous active-high reset
//   bus (slave)      : INTA sequence input, OCW2 EOI/priority strobes,
//                      registered ISR / rotation pointer, INTA status outputs
// Tracks the 2/3-pulse INTA sequence, sets ISR on the first pulse, clears it
// via normal/specific/auto EOI and owns the priority rotation pointer.
module in_service_control
    import in_service_control_pkg::*;
#(
    parameter logic [LEVEL_WIDTH-1:0] RESET_PRIORITY_ROTATE = 3'd7
) (
    input  logic                i_clock,
    input  logic                i_reset,
    in_service_control_if.slave bus
);

    ack_state_e             r_state, w_next_state;
    logic [IRQ_WIDTH-1:0]   r_isr;
    logic [LEVEL_WIDTH-1:0] r_rotate;
    logic                   r_rotate_in_aeoi;
    logic [IRQ_WIDTH-1:0]   r_ack_mask;
    logic [LEVEL_WIDTH-1:0] r_ack_level;
    logic                   r_mode_8086;
    logic                   r_ack_done;

    logic                   w_capture;
    logic                   w_ack_final;
    logic [IRQ_WIDTH-1:0]   w_set_mask;
    logic [IRQ_WIDTH-1:0]   w_clear_mask;
    logic [IRQ_WIDTH-1:0]   w_hls;
    logic                   w_aeoi;
    logic                   w_rot_we;
    logic [LEVEL_WIDTH-1:0] w_rot_next;

    HighestLevelServiceModule u_hls (
        .i_in_service_register (r_isr),
        .i_special_mask        (bus.interrupt_special_mask),
        .i_priority_rotate     (r_rotate),
        .o_highest_level       (w_hls)
    );

    // INTA sequence state register
    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    // INTA sequence next-state; the captured mode decides 2 vs 3 pulses
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_ack_final  = 1'b0;
        w_set_mask   = '0;
        case (r_state)
            IDLE: if (bus.inta_pulse) begin
                w_capture    = 1'b1;
                w_set_mask   = bus.acknowledge_interrupt;
                w_next_state = WAIT_2ND;
            end
            WAIT_2ND: if (bus.inta_pulse) begin
                if (r_mode_8086) begin
                    w_ack_final  = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = WAIT_3RD;
                end
            end
            WAIT_3RD: if (bus.inta_pulse) begin
                w_ack_final  = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ISR clear sources and rotation pointer write select
    always_comb begin
        w_aeoi       = w_ack_final && bus.auto_eoi_config;
        w_clear_mask = '0;
        w_rot_we     = 1'b0;
        w_rot_next   = r_rotate;
        if (bus.eoi_strobe) begin
            if (bus.eoi_specific) w_clear_mask = IRQ_WIDTH'(1) << bus.eoi_level;
            else                  w_clear_mask = w_hls;
        end
        if (w_aeoi) w_clear_mask = w_clear_mask | r_ack_mask;

        // Priority: set-priority, then EOI rotate, then AEOI rotate
        if (bus.set_priority_strobe) begin
            w_rot_we   = 1'b1;
            w_rot_next = bus.eoi_level;
        end else if (bus.eoi_strobe && bus.eoi_rotate && bus.eoi_specific) begin
            w_rot_we   = 1'b1;
            w_rot_next = bus.eoi_level;
        end else if (bus.eoi_strobe && bus.eoi_rotate && (w_hls != '0)) begin
            w_rot_we   = 1'b1;
            w_rot_next = onehot_to_level(w_hls);
        end else if (w_aeoi && r_rotate_in_aeoi && (r_ack_mask != '0)) begin
            w_rot_we   = 1'b1;
            w_rot_next = r_ack_level;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_isr            <= '0;
            r_rotate         <= RESET_PRIORITY_ROTATE;
            r_rotate_in_aeoi <= 1'b0;
            r_ack_mask       <= '0;
            r_ack_level      <= '0;
            r_mode_8086      <= 1'b0;
            r_ack_done       <= 1'b0;
        end else begin
            // Set wins over clear on the same bit
            r_isr      <= (r_isr & ~w_clear_mask) | w_set_mask;
            r_ack_done <= w_ack_final;
            if (w_rot_we) r_rotate <= w_rot_next;
            if (bus.rotate_in_aeoi_clear)    r_rotate_in_aeoi <= 1'b0;
            else if (bus.rotate_in_aeoi_set) r_rotate_in_aeoi <= 1'b1;
            if (w_capture) begin
                r_ack_mask  <= bus.acknowledge_interrupt;
                r_ack_level <= onehot_to_level(bus.acknowledge_interrupt);
                r_mode_8086 <= bus.mode_8086;
            end
        end
    end

    assign bus.in_service_register      = r_isr;
    assign bus.priority_rotate          = r_rotate;
    assign bus.highest_level_in_service = w_hls;
    assign bus.ack_busy                 = (r_state != IDLE);
    assign bus.ack_level                = r_ack_level;
    assign bus.ack_done                 = r_ack_done;

endmodule

// File: tb/tb_in_service_control.sv
module tb_in_service_control;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    in_service_control_if bus ();

    in_service_control #(.RESET_PRIORITY_ROTATE(3'd7)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    localparam int S_ISR = 0, S_ROT = 1, S_HLS = 2, S_BUSY = 3, S_LVL = 4, S_DONE = 5;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] obs(input int sel);
        case (sel)
            S_ISR:   return bus.in_service_register;
            S_ROT:   return {5'd0, bus.priority_rotate};
            S_HLS:   return bus.highest_level_in_service;
            S_BUSY:  return {7'd0, bus.ack_busy};
            S_LVL:   return {5'd0, bus.ack_level};
            default: return {7'd0, bus.ack_done};
        endcase
    endfunction

    task automatic exp(input string tag, input int sel, input logic [7:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = v;
        sb.push_back(e);
    endtask

    // One clock edge; then check everything queued for this cycle and drop strobes
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
        bus.inta_pulse           = 1'b0;
        bus.eoi_strobe           = 1'b0;
        bus.eoi_specific         = 1'b0;
        bus.eoi_rotate           = 1'b0;
        bus.set_priority_strobe  = 1'b0;
        bus.rotate_in_aeoi_set   = 1'b0;
        bus.rotate_in_aeoi_clear = 1'b0;
        rst                      = 1'b0;
    endtask

    task automatic inta(input logic [7:0] ack);
        bus.inta_pulse = 1'b1;
        bus.acknowledge_interrupt = ack;
    endtask

    task automatic eoi(input logic spec, input logic rot, input logic [2:0] lvl);
        bus.eoi_strobe = 1'b1; bus.eoi_specific = spec;
        bus.eoi_rotate = rot;  bus.eoi_level = lvl;
    endtask

    task automatic set_prio(input logic [2:0] lvl);
        bus.set_priority_strobe = 1'b1; bus.eoi_level = lvl;
    endtask

    // Full 8086 (two-pulse) acknowledge of one IR, no AEOI
    task automatic ack86(input logic [7:0] ack);
        bus.mode_8086 = 1'b1;
        inta(ack); cyc();
        inta(ack); cyc();
    endtask

    initial begin
        rst = 1'b1;
        bus.inta_pulse = 0; bus.mode_8086 = 0; bus.auto_eoi_config = 0;
        bus.acknowledge_interrupt = 0; bus.interrupt_special_mask = 0;
        bus.eoi_strobe = 0; bus.eoi_specific = 0; bus.eoi_rotate = 0; bus.eoi_level = 0;
        bus.set_priority_strobe = 0; bus.rotate_in_aeoi_set = 0; bus.rotate_in_aeoi_clear = 0;
        rst = 1'b1; @(posedge clk); #1;
        rst = 1'b1;
        exp("rst_isr", S_ISR, 8'h00); exp("rst_rot", S_ROT, 8'd7);
        exp("rst_busy", S_BUSY, 8'd0); exp("rst_lvl", S_LVL, 8'd0);
        exp("rst_done", S_DONE, 8'd0); exp("rst_hls", S_HLS, 8'h00);
        cyc();

        // 8086 two-pulse acknowledge of IR2
        bus.mode_8086 = 1'b1;
        inta(8'h04);
        exp("86_p1_isr", S_ISR, 8'h04); exp("86_p1_lvl", S_LVL, 8'd2);
        exp("86_p1_busy", S_BUSY, 8'd1); exp("86_p1_done", S_DONE, 8'd0);
        cyc();
        inta(8'h04);
        exp("86_p2_done", S_DONE, 8'd1); exp("86_p2_busy", S_BUSY, 8'd0);
        exp("86_p2_isr", S_ISR, 8'h04);
        cyc();
        exp("86_done_clr", S_DONE, 8'd0);
        cyc();
        eoi(1'b1, 1'b0, 3'd2);
        exp("spec_eoi2", S_ISR, 8'h00);
        cyc();

        // Non-specific EOI, then rotating non-specific EOI
        ack86(8'h02); ack86(8'h08);
        exp("isr_0a", S_ISR, 8'h0A); exp("hls_0a", S_HLS, 8'h02);
        cyc();
        eoi(1'b0, 1'b0, 3'd0);
        exp("ns_eoi_isr", S_ISR, 8'h08); exp("ns_eoi_rot", S_ROT, 8'd7);
        cyc();
        eoi(1'b0, 1'b1, 3'd0);
        exp("rot_eoi_isr", S_ISR, 8'h00); exp("rot_eoi_rot", S_ROT, 8'd3);
        cyc();
        // rotation 3: IR4 is highest, so IR5 beats IR1
        ack86(8'h02); ack86(8'h20);
        exp("rot3_hls", S_HLS, 8'h20);
        cyc();
        eoi(1'b0, 1'b0, 3'd0);
        exp("rot3_ns_eoi", S_ISR, 8'h02);
        cyc();
        eoi(1'b0, 1'b0, 3'd0);
        exp("rot3_ns_eoi2", S_ISR, 8'h00);
        cyc();
        eoi(1'b0, 1'b1, 3'd0);
        exp("empty_rot_eoi", S_ROT, 8'd3);
        cyc();
        set_prio(3'd7);
        exp("setprio7", S_ROT, 8'd7); exp("setprio_isr", S_ISR, 8'h00);
        cyc();

        // Special mask excludes IR1 from non-specific EOI
        ack86(8'h02); ack86(8'h08);
        bus.interrupt_special_mask = 8'h02;
        exp("smm_hls", S_HLS, 8'h08);
        cyc();
        eoi(1'b0, 1'b0, 3'd0);
        exp("smm_eoi", S_ISR, 8'h02);
        cyc();
        eoi(1'b0, 1'b0, 3'd0);
        exp("smm_all_masked", S_ISR, 8'h02);
        cyc();
        bus.interrupt_special_mask = 8'h00;
        eoi(1'b1, 1'b0, 3'd1);
        exp("smm_clear", S_ISR, 8'h00);
        cyc();

        // 8080 three-pulse with AEOI and rotate-in-AEOI
        bus.rotate_in_aeoi_set = 1'b1;
        cyc();
        bus.mode_8086 = 1'b0; bus.auto_eoi_config = 1'b1;
        inta(8'h20);
        exp("80_p1_isr", S_ISR, 8'h20); exp("80_p1_lvl", S_LVL, 8'd5);
        cyc();
        bus.mode_8086 = 1'b1;  // ignored after first pulse
        inta(8'h20);
        exp("80_p2_busy", S_BUSY, 8'd1); exp("80_p2_done", S_DONE, 8'd0);
        exp("80_p2_isr", S_ISR, 8'h20);
        cyc();
        inta(8'h20);
        exp("80_p3_isr", S_ISR, 8'h00); exp("80_p3_rot", S_ROT, 8'd5);
        exp("80_p3_done", S_DONE, 8'd1); exp("80_p3_busy", S_BUSY, 8'd0);
        cyc();
        bus.auto_eoi_config = 1'b0;
        bus.rotate_in_aeoi_clear = 1'b1; bus.rotate_in_aeoi_set = 1'b1;
        set_prio(3'd7);
        exp("restore_rot", S_ROT, 8'd7);
        cyc();
        // rotate_in_aeoi cleared (clear won): AEOI no longer rotates
        bus.auto_eoi_config = 1'b1;
        ack86(8'h08);
        exp("aeoi_norot_isr", S_ISR, 8'h00); exp("aeoi_norot_rot", S_ROT, 8'd7);
        cyc();
        bus.auto_eoi_config = 1'b0;

        // Specific EOI collides with the first INTA for the same level: set wins
        ack86(8'h40);
        inta(8'h40); eoi(1'b1, 1'b0, 3'd6);
        exp("setwins_isr", S_ISR, 8'h40);
        cyc();
        inta(8'h40);
        cyc();
        eoi(1'b1, 1'b0, 3'd6);
        exp("clr6", S_ISR, 8'h00);
        cyc();

        // Spurious acknowledge
        bus.mode_8086 = 1'b1;
        inta(8'h00);
        exp("spur_lvl", S_LVL, 8'd7); exp("spur_isr", S_ISR, 8'h00);
        exp("spur_busy", S_BUSY, 8'd1);
        cyc();
        inta(8'h00);
        exp("spur_done", S_DONE, 8'd1);
        cyc();

        // Reset while in WAIT_3RD
        set_prio(3'd4);
        exp("prio4", S_ROT, 8'd4);
        cyc();
        bus.mode_8086 = 1'b0;
        inta(8'h01); cyc();
        inta(8'h01);
        exp("w3_busy", S_BUSY, 8'd1); exp("w3_isr", S_ISR, 8'h01);
        cyc();
        rst = 1'b1;
        exp("mid_rst_isr", S_ISR, 8'h00); exp("mid_rst_rot", S_ROT, 8'd7);
        exp("mid_rst_busy", S_BUSY, 8'd0); exp("mid_rst_lvl", S_LVL, 8'd0);
        cyc();
        // a pulse after reset starts a fresh sequence
        bus.mode_8086 = 1'b1;
        inta(8'h10);
        exp("post_rst_isr", S_ISR, 8'h10); exp("post_rst_lvl", S_LVL, 8'd4);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
